// File: rtl/svc_rv_perf_ctr.sv
// Cycle / instret counter unit with the machine and user CSR views and mcountinhibit.
// Counting freezes permanently once halt is seen; CSR writes still land afterwards.
module svc_rv_perf_ctr #(
  parameter int COUNTER_W = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        retire,
  input  logic        halt,
  input  logic [11:0] csr_addr,
  input  logic        csr_rd_en,
  output logic [31:0] csr_rdata,
  output logic        csr_hit,
  input  logic        csr_wr_en,
  input  logic [1:0]  csr_wr_op,
  input  logic [31:0] csr_wdata,
  output logic        csr_illegal,
  output logic        halted
);

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CY_LO,
    SEL_CY_HI,
    SEL_IR_LO,
    SEL_IR_HI,
    SEL_INH
  } csr_sel_e;

  logic [COUNTER_W-1:0] cycle_q, cycle_d;
  logic [COUNTER_W-1:0] instret_q, instret_d;
  logic                 inh_cy_q, inh_cy_d;
  logic                 inh_ir_q, inh_ir_d;
  logic                 halted_q, halted_d;
  logic                 illegal_q, illegal_d;

  csr_sel_e    sel;
  logic        ro;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        wr_attempt;
  logic        wr_legal;
  logic        cy_en;
  logic        ir_en;
  logic [63:0] cycle_ext, instret_ext;
  logic [63:0] cycle_nxt, instret_nxt;

  // Zero-extend to 64 so a 32-bit build reads 0 from the high halves.
  assign cycle_ext   = 64'(cycle_q);
  assign instret_ext = 64'(instret_q);

  always_comb begin
    sel = SEL_NONE;
    ro  = 1'b0;
    case (csr_addr)
      12'hB00: sel = SEL_CY_LO;
      12'hB80: sel = SEL_CY_HI;
      12'hB02: sel = SEL_IR_LO;
      12'hB82: sel = SEL_IR_HI;
      12'hC00: begin sel = SEL_CY_LO; ro = 1'b1; end
      12'hC80: begin sel = SEL_CY_HI; ro = 1'b1; end
      12'hC02: begin sel = SEL_IR_LO; ro = 1'b1; end
      12'hC82: begin sel = SEL_IR_HI; ro = 1'b1; end
      12'h320: sel = SEL_INH;
      default: sel = SEL_NONE;
    endcase
  end

  assign csr_hit = (sel != SEL_NONE);

  always_comb begin
    old_val = 32'd0;
    case (sel)
      SEL_CY_LO: old_val = cycle_ext[31:0];
      SEL_CY_HI: old_val = cycle_ext[63:32];
      SEL_IR_LO: old_val = instret_ext[31:0];
      SEL_IR_HI: old_val = instret_ext[63:32];
      SEL_INH:   old_val = {29'd0, inh_ir_q, 1'b0, inh_cy_q};
      default:   old_val = 32'd0;
    endcase
  end

  assign csr_rdata = csr_rd_en ? old_val : 32'd0;

  always_comb begin
    new_val = old_val;
    case (csr_wr_op)
      2'd0:    new_val = csr_wdata;
      2'd1:    new_val = old_val | csr_wdata;
      2'd2:    new_val = old_val & ~csr_wdata;
      default: new_val = old_val;
    endcase
  end

  // Reserved op 3 is silently ignored, even on a read-only alias.
  assign wr_attempt = csr_wr_en && csr_hit && (csr_wr_op != 2'd3);
  assign wr_legal   = wr_attempt && !ro;
  assign illegal_d  = wr_attempt && ro;

  // Halt on this edge already blocks counting, so the ebreak retire is dropped.
  assign cy_en = !halted_q && !halt && !inh_cy_q;
  assign ir_en = retire && !halted_q && !halt && !inh_ir_q;

  // A write to either half suppresses the increment of the whole counter.
  always_comb begin
    cycle_nxt = cycle_ext;
    if (wr_legal && sel == SEL_CY_LO)      cycle_nxt[31:0]  = new_val;
    else if (wr_legal && sel == SEL_CY_HI) cycle_nxt[63:32] = new_val;
    else if (cy_en)                        cycle_nxt        = cycle_ext + 64'd1;
    cycle_d = cycle_nxt[COUNTER_W-1:0];
  end

  always_comb begin
    instret_nxt = instret_ext;
    if (wr_legal && sel == SEL_IR_LO)      instret_nxt[31:0]  = new_val;
    else if (wr_legal && sel == SEL_IR_HI) instret_nxt[63:32] = new_val;
    else if (ir_en)                        instret_nxt        = instret_ext + 64'd1;
    instret_d = instret_nxt[COUNTER_W-1:0];
  end

  always_comb begin
    inh_cy_d = inh_cy_q;
    inh_ir_d = inh_ir_q;
    if (wr_legal && sel == SEL_INH) begin
      inh_cy_d = new_val[0];
      inh_ir_d = new_val[2];
    end
  end

  assign halted_d = halted_q | halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
      inh_cy_q  <= 1'b0;
      inh_ir_q  <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      inh_cy_q  <= inh_cy_d;
      inh_ir_q  <= inh_ir_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign csr_illegal = illegal_q;
  assign halted      = halted_q;

endmodule
